// File: rtl/video_stream_player.sv
// video_stream_player
// Pulls pixels from a ready/valid source and replays them as camera-style
// vsync/href/pixel timing for num_frames frames, with configurable sync,
// gap, blanking and drain periods. It also counts the consumer's dut_valid
// strobes over the run and flags a count mismatch and any source underrun.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, num_frames one-cycle run request, frame count sampled on accept
//   src_valid/data    pixel source (never stalled; src_ready = in LINE)
//   src_ready         pixel consumed this cycle
//   vsync, href,      registered camera timing to the consumer
//   pixel_out
//   dut_valid         consumer output strobe, counted while busy
//   busy, done        run in progress, one-cycle end-of-run pulse
//   frame_idx         current frame, 0-based
//   out_count         saturating dut_valid count for this run
//   count_mismatch    out_count != EXP_PER_FRAME*num_frames, latched at done
//   underrun          sticky: source empty during an active pixel
module video_stream_player #(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int PIXEL_WIDTH   = 16,
  parameter int VSYNC_LEN     = 1,
  parameter int VSYNC_GAP     = 1,
  parameter int H_BLANK       = 2,
  parameter int V_BLANK       = 160,
  parameter int DRAIN_CYCLES  = 2560,
  parameter int EXP_PER_FRAME = (IMG_HEIGHT - 2) * (IMG_WIDTH - 1),
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            num_frames,
  input  logic                   src_valid,
  input  logic [PIXEL_WIDTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   vsync,
  output logic                   href,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  input  logic                   dut_valid,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            frame_idx,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   count_mismatch,
  output logic                   underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VGAP, S_LINE, S_HBLANK, S_VBLANK, S_DRAIN, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            ph_q, ph_d;
  logic [15:0]            row_q, row_d;
  logic [15:0]            nf_q, nf_d;
  logic [15:0]            frame_idx_q, frame_idx_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic                   underrun_q, underrun_d;
  logic                   mismatch_q, mismatch_d;
  logic                   vsync_q, vsync_d;
  logic                   href_q, href_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  state_t                 eof_state, eol_state;
  logic                   ph_last, last_row, more_frames;
  logic [CNT_WIDTH-1:0]   exp_total;

  // Dwell time of each timed state; IDLE/DONE are single-cycle.
  function automatic logic [31:0] state_len(input state_t s);
    case (s)
      S_VSYNC:  return 32'(VSYNC_LEN);
      S_VGAP:   return 32'(VSYNC_GAP);
      S_LINE:   return 32'(IMG_WIDTH);
      S_HBLANK: return 32'(H_BLANK);
      S_VBLANK: return 32'(V_BLANK);
      S_DRAIN:  return 32'(DRAIN_CYCLES);
      default:  return 32'd1;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Modulo-2^CNT_WIDTH product, so truncating num_frames first is exact.
  assign exp_total = CNT_WIDTH'(EXP_PER_FRAME) * CNT_WIDTH'(nf_q);

  // Source is consumed unconditionally in LINE; never during reset.
  assign src_ready = (state_q == S_LINE) && !rst;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    row_d       = row_q;
    nf_d        = nf_q;
    frame_idx_d = frame_idx_q;
    out_count_d = out_count_q;
    underrun_d  = underrun_q;
    mismatch_d  = mismatch_q;

    ph_last     = (ph_q == state_len(state_q) - 32'd1);
    last_row    = (row_q == 16'(IMG_HEIGHT - 1));
    more_frames = ((frame_idx_q + 16'd1) < nf_q);
    // Zero-length blanking/drain periods fall straight through to the
    // following state, so the exit chain is resolved here.
    eof_state   = more_frames ? S_VSYNC : ((DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE);
    eol_state   = !last_row ? S_LINE : ((V_BLANK > 0) ? S_VBLANK : eof_state);

    // Registered timing outputs follow the current state one cycle later.
    vsync_d = (state_q == S_VSYNC);
    href_d  = (state_q == S_LINE);
    pixel_d = ((state_q == S_LINE) && src_valid) ? src_data : '0;
    done_d  = (state_q == S_DONE);
    busy_d  = (state_q != S_IDLE);

    if (state_q != S_IDLE && dut_valid) out_count_d = sat_inc(out_count_q);
    if (state_q == S_LINE && !src_valid) underrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nf_d        = num_frames;
          out_count_d = '0;
          underrun_d  = 1'b0;
          mismatch_d  = 1'b0;
          frame_idx_d = '0;
          row_d       = '0;
          ph_d        = '0;
          state_d     = (num_frames != 16'd0) ? S_VSYNC : S_DONE;
        end
      end
      S_DONE: begin
        mismatch_d = (out_count_d != exp_total);
        state_d    = S_IDLE;
      end
      default: begin
        if (ph_last) begin
          ph_d = '0;
          case (state_q)
            S_VSYNC:  state_d = (VSYNC_GAP > 0) ? S_VGAP : S_LINE;
            S_VGAP:   state_d = S_LINE;
            S_LINE:   state_d = (H_BLANK > 0) ? S_HBLANK : eol_state;
            S_HBLANK: state_d = eol_state;
            S_VBLANK: state_d = eof_state;
            default:  state_d = S_DONE;
          endcase
          if ((state_q == S_LINE || state_q == S_HBLANK) && state_d == S_LINE)
            row_d = row_q + 16'd1;
          if (state_d == S_VSYNC) begin
            row_d       = '0;
            frame_idx_d = frame_idx_q + 16'd1;
          end
        end else begin
          ph_d = ph_q + 32'd1;
        end
      end
    endcase
  end

  // State and output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      row_q       <= '0;
      nf_q        <= '0;
      frame_idx_q <= '0;
      out_count_q <= '0;
      underrun_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      pixel_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      row_q       <= row_d;
      nf_q        <= nf_d;
      frame_idx_q <= frame_idx_d;
      out_count_q <= out_count_d;
      underrun_q  <= underrun_d;
      mismatch_q  <= mismatch_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      pixel_q     <= pixel_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign vsync          = vsync_q;
  assign href           = href_q;
  assign pixel_out      = pixel_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign frame_idx      = frame_idx_q;
  assign out_count      = out_count_q;
  assign count_mismatch = mismatch_q;
  assign underrun       = underrun_q;

endmodule
